// File: rtl/span_rasterizer.sv
// span_rasterizer: walks one horizontal span, issuing one fragment at a time
// to a depth comparator and waiting for its written handshake before moving on.
//
// Ports
//   clock, reset        sole clock; synchronous active-high reset
//   span_valid/ready    span descriptor handshake (ready only when idle)
//   span_y              row of the span
//   span_x_start/_end   inclusive column bounds (end clipped to X_MAX)
//   span_depth          depth at x_start (unsigned)
//   span_depth_step     signed per-column depth increment
//   span_color          constant color for the whole span
//   pixel_out           current fragment {x, y, depth, color}
//   pixel_valid         fragment presented to the depth comparator
//   pixel_written       comparator done flag; a low-then-high sequence retires
//   busy                a span is in progress

package span_raster_pkg;
    localparam int DEPTH_W = 16;
    localparam int COLOR_W = 24;
    localparam int COORD_W = 10;

    typedef struct packed {
        logic [DEPTH_W-1:0] depth;
        logic [COLOR_W-1:0] color;
    } pixel_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        pixel_t             pixel;
    } pixel_info_t;
endpackage

// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a span, no fragment outstanding
// ISSUE     | fragment presented, waiting for written to go low
// WAIT_DONE | written seen low, waiting for it to rise to retire fragment
module span_rasterizer
    import span_raster_pkg::*;
#(
    parameter int X_MAX   = 639,
    parameter int DEPTH_W = span_raster_pkg::DEPTH_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                span_valid,
    output logic                span_ready,
    input  logic [9:0]          span_y,
    input  logic [9:0]          span_x_start,
    input  logic [9:0]          span_x_end,
    input  logic [DEPTH_W-1:0]  span_depth,
    input  logic [DEPTH_W-1:0]  span_depth_step,
    input  logic [COLOR_W-1:0]  span_color,
    output pixel_info_t         pixel_out,
    output logic                pixel_valid,
    input  logic                pixel_written,
    output logic                busy
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    localparam logic [9:0]         X_MAX_L   = 10'(X_MAX);
    localparam logic [DEPTH_W-1:0] DEPTH_MAX = '1;

    logic [1:0]         state;
    logic [9:0]         x_q;
    logic [9:0]         x_end_q;
    logic [9:0]         y_q;
    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] step_q;
    logic [COLOR_W-1:0] color_q;

    logic [9:0]         eff_end;
    logic               span_empty;
    logic               accept;
    logic               last_col;
    // Two guard bits so an unsigned depth plus a signed step can never wrap
    // before the saturation compare.
    logic signed [DEPTH_W+1:0] depth_sum;
    logic [DEPTH_W-1:0]        depth_next;

    assign eff_end    = (span_x_end > X_MAX_L) ? X_MAX_L : span_x_end;
    assign span_empty = span_x_start > eff_end;
    assign span_ready = (state == IDLE);
    assign accept     = span_valid && span_ready;
    assign last_col   = (x_q == x_end_q);

    assign depth_sum = $signed({2'b00, depth_q})
                     + $signed({{2{step_q[DEPTH_W-1]}}, step_q});

    always_comb begin
        depth_next = depth_sum[DEPTH_W-1:0];
        if (depth_sum < 0)
            depth_next = '0;
        else if (depth_sum > $signed({2'b00, DEPTH_MAX}))
            depth_next = DEPTH_MAX;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            x_q     <= '0;
            x_end_q <= '0;
            y_q     <= '0;
            depth_q <= '0;
            step_q  <= '0;
            color_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Empty spans are consumed here without touching the
                    // fragment registers.
                    if (accept && !span_empty) begin
                        state   <= ISSUE;
                        x_q     <= span_x_start;
                        x_end_q <= eff_end;
                        y_q     <= span_y;
                        depth_q <= span_depth;
                        step_q  <= span_depth_step;
                        color_q <= span_color;
                    end
                end
                ISSUE: begin
                    if (!pixel_written)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (pixel_written) begin
                        if (last_col) begin
                            state <= IDLE;
                        end else begin
                            state   <= ISSUE;
                            x_q     <= x_q + 10'd1;
                            depth_q <= depth_next;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pixel_valid = (state == ISSUE) || (state == WAIT_DONE);
    assign busy        = (state != IDLE);

    assign pixel_out.x           = x_q;
    assign pixel_out.y           = y_q;
    assign pixel_out.pixel.depth = depth_q;
    assign pixel_out.pixel.color = color_q;

endmodule

// File: tb/tb_span_rasterizer.sv
// Self-checking bench for span_rasterizer: directed spans plus random spans,
// each compared fragment by fragment against a list built from the span rules.
module tb_span_rasterizer;
    import span_raster_pkg::*;

    localparam int X_MAX = 639;

    logic               clock = 1'b0;
    logic               reset;
    logic               span_valid;
    logic               span_ready;
    logic [9:0]         span_y;
    logic [9:0]         span_x_start;
    logic [9:0]         span_x_end;
    logic [15:0]        span_depth;
    logic [15:0]        span_depth_step;
    logic [23:0]        span_color;
    pixel_info_t        pixel_out;
    logic               pixel_valid;
    logic               pixel_written;
    logic               busy;

    int checks = 0;
    int errors = 0;

    span_rasterizer #(.X_MAX(X_MAX), .DEPTH_W(16)) dut (
        .clock           (clock),
        .reset           (reset),
        .span_valid      (span_valid),
        .span_ready      (span_ready),
        .span_y          (span_y),
        .span_x_start    (span_x_start),
        .span_x_end      (span_x_end),
        .span_depth      (span_depth),
        .span_depth_step (span_depth_step),
        .span_color      (span_color),
        .pixel_out       (pixel_out),
        .pixel_valid     (pixel_valid),
        .pixel_written   (pixel_written),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected fragments from the span rules: clip end to X_MAX, depth
    // accumulates the signed step and clamps to [0, 65535].
    task automatic build_model(input logic [9:0] y, input logic [9:0] xs, input logic [9:0] xe,
                               input logic [15:0] d, input logic [15:0] st, input logic [23:0] c,
                               output pixel_info_t q[$]);
        int last_x;
        int dv;
        int sv;
        pixel_info_t f;
        q = {};
        last_x = (int'(xe) < X_MAX) ? int'(xe) : X_MAX;
        dv = int'(d);
        sv = int'($signed(st));
        for (int x = int'(xs); x <= last_x; x++) begin
            f.x = 10'(x);
            f.y = y;
            f.pixel.depth = 16'(dv);
            f.pixel.color = c;
            q.push_back(f);
            dv = dv + sv;
            if (dv < 0) dv = 0;
            if (dv > 65535) dv = 65535;
        end
    endtask

    // hold: cycles of written=1 in ISSUE before the first handshake.
    // abort_at: fragment index at which reset is asserted instead (-1 = none).
    task automatic run_span(input string name, input logic [9:0] y, input logic [9:0] xs,
                            input logic [9:0] xe, input logic [15:0] d, input logic [15:0] st,
                            input logic [23:0] c, input int hold, input int abort_at);
        pixel_info_t q[$];
        int waited;
        build_model(y, xs, xe, d, st, c, q);
        @(negedge clock);
        check({name, " ready_before"}, 64'(span_ready), 64'd1);
        span_y = y; span_x_start = xs; span_x_end = xe;
        span_depth = d; span_depth_step = st; span_color = c;
        span_valid = 1'b1;
        @(negedge clock);
        span_valid = 1'b0;
        if (q.size() == 0) begin
            for (int k = 0; k < 3; k++) begin
                check({name, " empty_busy"}, 64'(busy), 64'd0);
                check({name, " empty_pv"}, 64'(pixel_valid), 64'd0);
                check({name, " empty_ready"}, 64'(span_ready), 64'd1);
                @(negedge clock);
            end
            return;
        end
        for (int i = 0; i < q.size(); i++) begin
            if (i == abort_at) begin
                reset = 1'b1;
                span_valid = 1'b1;
                span_x_start = 10'd0; span_x_end = 10'd5;
                @(negedge clock);
                reset = 1'b0;
                span_valid = 1'b0;
                check({name, " abort_pv"}, 64'(pixel_valid), 64'd0);
                check({name, " abort_ready"}, 64'(span_ready), 64'd1);
                check({name, " abort_busy"}, 64'(busy), 64'd0);
                check({name, " abort_pout"}, 64'(pixel_out), 64'd0);
                @(negedge clock);
                check({name, " abort_busy2"}, 64'(busy), 64'd0);
                return;
            end
            waited = 0;
            while (!pixel_valid && waited < 10) begin
                @(negedge clock);
                waited++;
            end
            if (!pixel_valid) begin
                check({name, " valid_timeout"}, 64'd0, 64'd1);
                return;
            end
            check({name, " frag"}, 64'(pixel_out), 64'(q[i]));
            check({name, " busy"}, 64'(busy), 64'd1);
            check({name, " ready_busy"}, 64'(span_ready), 64'd0);
            if (i == 0 && hold > 0) begin
                pixel_written = 1'b1;
                for (int h = 0; h < hold; h++) begin
                    @(negedge clock);
                    check({name, " hold_frag"}, 64'(pixel_out), 64'(q[i]));
                    check({name, " hold_pv"}, 64'(pixel_valid), 64'd1);
                end
            end
            // Comparator drops written; a stray span pulse must be ignored.
            pixel_written = 1'b0;
            span_valid = 1'b1;
            span_x_start = 10'($urandom_range(0, 600));
            span_x_end = span_x_start + 10'd3;
            span_y = 10'($urandom);
            @(negedge clock);
            span_valid = 1'b0;
            check({name, " stable"}, 64'(pixel_out), 64'(q[i]));
            check({name, " wait_pv"}, 64'(pixel_valid), 64'd1);
            pixel_written = 1'b1;
            @(negedge clock);
            pixel_written = 1'b0;
        end
        check({name, " done_busy"}, 64'(busy), 64'd0);
        check({name, " done_pv"}, 64'(pixel_valid), 64'd0);
        check({name, " done_ready"}, 64'(span_ready), 64'd1);
    endtask

    initial begin
        logic [9:0] xs;
        logic [9:0] xe;
        reset = 1'b1;
        span_valid = 1'b0;
        pixel_written = 1'b0;
        span_y = '0; span_x_start = '0; span_x_end = '0;
        span_depth = '0; span_depth_step = '0; span_color = '0;

        @(negedge clock);
        check("reset_pv", 64'(pixel_valid), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ready", 64'(span_ready), 64'd1);
        check("reset_pout", 64'(pixel_out), 64'd0);
        reset = 1'b0;

        run_span("basic", 10'd5, 10'd10, 10'd12, 16'd100, 16'd4, 24'hA1B2C3, 0, -1);
        run_span("clip", 10'd7, 10'd630, 10'd700, 16'd1000, 16'hFFFF, 24'h00FF00, 0, -1);
        run_span("empty", 10'd3, 10'd20, 10'd19, 16'd5, 16'd1, 24'h123456, 0, -1);
        run_span("under", 10'd1, 10'd0, 10'd3, 16'd10, 16'hFFFA, 24'h0000FF, 0, -1);
        run_span("over", 10'd2, 10'd50, 10'd51, 16'hFFF0, 16'h0020, 24'hFF0000, 0, -1);
        run_span("single", 10'd9, 10'd639, 10'd1000, 16'd7, 16'd1, 24'h777777, 0, -1);
        run_span("hold", 10'd4, 10'd100, 10'd102, 16'd500, 16'd3, 24'h0F0F0F, 5, -1);
        run_span("abort", 10'd8, 10'd200, 10'd204, 16'd50, 16'd2, 24'hABCDEF, 0, 2);
        run_span("after_abort", 10'd11, 10'd300, 10'd302, 16'd60, 16'hFFFE, 24'h010203, 0, -1);

        for (int n = 0; n < 20; n++) begin
            xs = 10'($urandom_range(1, 638));
            if ($urandom_range(0, 4) == 0)
                xe = xs - 10'd1;
            else if ($urandom_range(0, 4) == 0)
                xe = 10'($urandom_range(636, 1023));
            else
                xe = xs + 10'($urandom_range(0, 5));
            run_span("rand", 10'($urandom), xs, xe, 16'($urandom), 16'($urandom),
                     24'($urandom), $urandom_range(0, 2), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
